// File: rtl/ofmap_writer_l8.sv
// ofmap_writer_l8: layer-8 output-feature-map write-address generator (raster col/row/ch walk, registered write port).
// Optional macro OFMAP_RELU_EN fuses a ReLU into the write data path.
module ofmap_writer_l8 #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12,
  parameter int W_OUT  = 8,
  parameter int H_OUT  = 8,
  parameter int C_OUT  = 4,
  parameter int BASE   = 0,
  localparam int CW = W_OUT > 1 ? $clog2(W_OUT) : 1,
  localparam int RW = H_OUT > 1 ? $clog2(H_OUT) : 1,
  localparam int NW = C_OUT > 1 ? $clog2(C_OUT) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        u,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [CW-1:0]     col,
  output logic [RW-1:0]     row,
  output logic [NW-1:0]     ch,
  output logic              busy,
  output logic              done
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;
  state_t            r_state;
  logic              r_half;
  logic [ADDR_W-1:0] r_addr;
  logic              w_acc, w_col_end, w_row_end, w_ch_end, w_last;
  logic [CW-1:0]     w_col_max;
  logic [RW-1:0]     w_row_max;
  logic [DATA_W-1:0] w_data;
  assign w_col_max = r_half ? CW'(W_OUT / 2 - 1) : CW'(W_OUT - 1);
  assign w_row_max = r_half ? RW'(H_OUT / 2 - 1) : RW'(H_OUT - 1);
  assign w_acc     = in_valid && in_ready;
  assign w_col_end = col == w_col_max;
  assign w_row_end = row == w_row_max;
  assign w_ch_end  = ch == NW'(C_OUT - 1);
  assign w_last    = w_col_end && w_row_end && w_ch_end;
`ifdef OFMAP_RELU_EN
  assign w_data = in_data[DATA_W-1] ? '0 : in_data;
`else
  assign w_data = in_data;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state  <= S_IDLE;
      r_half   <= 1'b0;
      r_addr   <= ADDR_W'(BASE);
      in_ready <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      col      <= '0;
      row      <= '0;
      ch       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      wr_en <= w_acc;
      if (w_acc) begin
        wr_addr <= r_addr;
        wr_data <= w_data;
        r_addr  <= r_addr + 1'b1;
        col     <= w_col_end ? '0 : col + 1'b1;
        if (w_col_end) row <= w_row_end ? '0 : row + 1'b1;
        if (w_col_end && w_row_end) ch <= w_ch_end ? '0 : ch + 1'b1;
      end
      case (r_state)
        S_IDLE: if (start) begin
          r_state  <= S_RUN;
          r_half   <= u == 3'd2;
          r_addr   <= ADDR_W'(BASE);
          col      <= '0;
          row      <= '0;
          ch       <= '0;
          in_ready <= 1'b1;
          busy     <= 1'b1;
        end
        S_RUN: if (w_acc && w_last) begin
          r_state  <= S_FLUSH;
          in_ready <= 1'b0;
        end
        S_FLUSH: begin
          r_state <= S_DONE;
          busy    <= 1'b0;
          done    <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          done    <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_ofmap_writer_l8.sv
// tb_ofmap_writer_l8: randomized self-checking bench; expected writes and counters come from beat-index arithmetic.
module tb_ofmap_writer_l8;
  localparam int DW = 16, AW = 12, W = 8, H = 8, C = 4, BASE = 0;
  logic clk = 0, rst = 0, start = 0, in_valid = 0;
  logic [2:0] u = 0;
  logic [DW-1:0] in_data = 0;
  logic in_ready, wr_en, busy, done;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [2:0] col, row;
  logic [1:0] ch;
  int total_n = 0, bad_n = 0;

  ofmap_writer_l8 #(.DATA_W(DW), .ADDR_W(AW), .W_OUT(W), .H_OUT(H), .C_OUT(C), .BASE(BASE)) dut (
    .clk(clk), .rst(rst), .start(start), .u(u), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .col(col), .row(row), .ch(ch), .busy(busy), .done(done));

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] relu(input logic [DW-1:0] d);
`ifdef OFMAP_RELU_EN
    return d[DW-1] ? '0 : d;
`else
    return d;
`endif
  endfunction

  // Drives one pass and checks every cycle; abort_at>0 drops reset after that many beats.
  task automatic drive_pass(input int mode, input int duty, input bit poke, input int abort_at);
    int ws, hs, total, k, cyc;
    bit pa;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed, d;
    ws = (mode == 2) ? W / 2 : W;
    hs = (mode == 2) ? H / 2 : H;
    total = C * ws * hs;
    k = 0; cyc = 0; pa = 0; ea = 0; ed = 0;
    @(negedge clk);
    start = 1; u = 3'(mode);
    @(negedge clk);
    start = 0; u = 3'($urandom_range(7));
    while (k < total && cyc < 20 * total + 50) begin
      total_n += 7;
      if (in_ready !== 1'b1) begin bad_n++; $display("FAIL run_ready k=%0d got=%b want=1", k, in_ready); end
      if (busy !== 1'b1) begin bad_n++; $display("FAIL run_busy k=%0d got=%b want=1", k, busy); end
      if (done !== 1'b0) begin bad_n++; $display("FAIL run_done k=%0d got=%b want=0", k, done); end
      if (wr_en !== pa) begin bad_n++; $display("FAIL wr_en k=%0d got=%b want=%b", k, wr_en, pa); end
      if (col !== 3'(k % ws)) begin bad_n++; $display("FAIL col k=%0d got=%0d want=%0d", k, col, k % ws); end
      if (row !== 3'((k / ws) % hs)) begin bad_n++; $display("FAIL row k=%0d got=%0d want=%0d", k, row, (k / ws) % hs); end
      if (ch !== 2'((k / (ws * hs)) % C)) begin bad_n++; $display("FAIL ch k=%0d got=%0d want=%0d", k, ch, (k / (ws * hs)) % C); end
      if (pa) begin
        total_n += 2;
        if (wr_addr !== ea) begin bad_n++; $display("FAIL wr_addr k=%0d got=%0d want=%0d", k, wr_addr, ea); end
        if (wr_data !== ed) begin bad_n++; $display("FAIL wr_data k=%0d got=%h want=%h", k, wr_data, ed); end
      end
      if (abort_at > 0 && k == abort_at) begin
        rst = 0; in_valid = 0;
        #1;
        total_n += 9;
        if (in_ready !== 1'b0) begin bad_n++; $display("FAIL rst_ready got=%b want=0", in_ready); end
        if (wr_en !== 1'b0) begin bad_n++; $display("FAIL rst_wr_en got=%b want=0", wr_en); end
        if (wr_addr !== '0) begin bad_n++; $display("FAIL rst_wr_addr got=%0d want=0", wr_addr); end
        if (wr_data !== '0) begin bad_n++; $display("FAIL rst_wr_data got=%h want=0", wr_data); end
        if (col !== '0) begin bad_n++; $display("FAIL rst_col got=%0d want=0", col); end
        if (row !== '0) begin bad_n++; $display("FAIL rst_row got=%0d want=0", row); end
        if (ch !== '0) begin bad_n++; $display("FAIL rst_ch got=%0d want=0", ch); end
        if (busy !== 1'b0) begin bad_n++; $display("FAIL rst_busy got=%b want=0", busy); end
        if (done !== 1'b0) begin bad_n++; $display("FAIL rst_done got=%b want=0", done); end
        @(negedge clk);
        rst = 1;
        return;
      end
      in_valid = $urandom_range(99) < duty;
      d = (k == 0) ? 16'hFF85 : (k == 1) ? 16'h007B : 16'($urandom);
      in_data = d;
      start = poke ? 1'($urandom_range(1)) : 1'b0;
      pa = in_valid;
      if (in_valid) begin
        ea = AW'(BASE + k);
        ed = relu(d);
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 0;
    if (k < total) begin
      total_n++; bad_n++;
      $display("FAIL timeout beats got=%0d want=%0d", k, total);
    end
    start = poke;
    total_n += 9;
    if (wr_en !== 1'b1) begin bad_n++; $display("FAIL last_wr_en got=%b want=1", wr_en); end
    if (wr_addr !== AW'(BASE + total - 1)) begin bad_n++; $display("FAIL last_addr got=%0d want=%0d", wr_addr, BASE + total - 1); end
    if (wr_data !== ed) begin bad_n++; $display("FAIL last_data got=%h want=%h", wr_data, ed); end
    if (in_ready !== 1'b0) begin bad_n++; $display("FAIL flush_ready got=%b want=0", in_ready); end
    if (busy !== 1'b1) begin bad_n++; $display("FAIL flush_busy got=%b want=1", busy); end
    if (done !== 1'b0) begin bad_n++; $display("FAIL flush_done got=%b want=0", done); end
    if (col !== '0) begin bad_n++; $display("FAIL end_col got=%0d want=0", col); end
    if (row !== '0) begin bad_n++; $display("FAIL end_row got=%0d want=0", row); end
    if (ch !== '0) begin bad_n++; $display("FAIL end_ch got=%0d want=0", ch); end
    @(negedge clk);
    total_n += 4;
    if (done !== 1'b1) begin bad_n++; $display("FAIL done_pulse got=%b want=1", done); end
    if (busy !== 1'b0) begin bad_n++; $display("FAIL done_busy got=%b want=0", busy); end
    if (wr_en !== 1'b0) begin bad_n++; $display("FAIL done_wr_en got=%b want=0", wr_en); end
    if (in_ready !== 1'b0) begin bad_n++; $display("FAIL done_ready got=%b want=0", in_ready); end
    @(negedge clk);
    start = 0;
    total_n += 3;
    if (done !== 1'b0) begin bad_n++; $display("FAIL idle_done got=%b want=0", done); end
    if (busy !== 1'b0) begin bad_n++; $display("FAIL idle_busy got=%b want=0", busy); end
    if (in_ready !== 1'b0) begin bad_n++; $display("FAIL idle_ready got=%b want=0", in_ready); end
  endtask

  task automatic test_reset;
    #2;
    total_n += 5;
    if (in_ready !== 1'b0) begin bad_n++; $display("FAIL reset_ready got=%b want=0", in_ready); end
    if (wr_en !== 1'b0) begin bad_n++; $display("FAIL reset_wr_en got=%b want=0", wr_en); end
    if ({wr_addr, wr_data} !== '0) begin bad_n++; $display("FAIL reset_write got=%h want=0", {wr_addr, wr_data}); end
    if ({col, row, ch} !== '0) begin bad_n++; $display("FAIL reset_pos got=%h want=0", {col, row, ch}); end
    if ({busy, done} !== 2'b00) begin bad_n++; $display("FAIL reset_status got=%b want=00", {busy, done}); end
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    total_n++;
    if ({in_ready, busy, done, wr_en} !== 4'b0) begin bad_n++; $display("FAIL idle_quiet got=%b want=0000", {in_ready, busy, done, wr_en}); end
  endtask

  task automatic test_full;       drive_pass(0, 100, 0, 0); endtask
  task automatic test_half;       drive_pass(2, 100, 0, 0); endtask
  task automatic test_other_mode; drive_pass(5, 100, 0, 0); endtask
  task automatic test_gaps;       drive_pass(0, 50, 0, 0); drive_pass(2, 50, 0, 0); endtask
  task automatic test_start_poke; drive_pass(0, 70, 1, 0); endtask
  task automatic test_mid_reset;  drive_pass(0, 100, 0, 100); drive_pass(0, 100, 0, 0); endtask
  task automatic test_back_to_back; drive_pass(2, 100, 0, 0); drive_pass(0, 80, 0, 0); endtask

  initial begin
    test_reset();
    test_full();
    test_half();
    test_other_mode();
    test_gaps();
    test_start_poke();
    test_mid_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end
endmodule

// File: doc/ofmap_writer_l8.md
# ofmap_writer_l8

Output-feature-map write-address generator for layer 8. It is the write-side counterpart of the layer-8 read-index counters. It accepts result beats from the MAC/accumulator stage over a valid/ready handshake and walks column, row and channel counters in raster order. It drives a registered write port into the output buffer and pulses `done` once the last pixel of the layer is written.

## Interface
- `DATA_W`, 16, result/write data width (signed two's complement)
- `ADDR_W`, 12, output-buffer address width
- `W_OUT`, 8, full-resolution output width (columns); must be even
- `H_OUT`, 8, full-resolution output height (rows); must be even
- `C_OUT`, 4, output channels
- `BASE`, 0, first buffer address written

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `start`  in  1  one-cycle request to begin a layer pass; ignored unless idle
- `u`  in  3  mode, sampled on accepted `start`; 2 = stride-2 (half width/height), all other values = full resolution
- `in_valid`  in  1  result beat available
- `in_data`  in  DATA_W  result beat
- `in_ready`  out  1  block accepts a beat this cycle
- `wr_en`  out  1  buffer write strobe
- `wr_addr`  out  ADDR_W  buffer write address
- `wr_data`  out  DATA_W  buffer write data
- `col`, `row`  out  $clog2(W_OUT), $clog2(H_OUT)  position of the next beat to be accepted
- `ch`  out  $clog2(C_OUT)  channel of the next beat to be accepted
- `busy`  out  1  high in RUN and FLUSH
- `done`  out  1  one-cycle completion pulse

## Operation
- States:
  - IDLE: `start` -> RUN; latch `half = (u==2)`; clear `col`, `row`, `ch`; set linear address to `BASE`.
  - RUN: `in_ready=1`. A beat is accepted when `in_valid && in_ready`.
  - RUN -> FLUSH on acceptance of the last beat.
  - FLUSH -> DONE unconditionally.
  - DONE -> IDLE unconditionally.
- Effective dimensions: `Ws = half ? W_OUT/2 : W_OUT`, `Hs = half ? H_OUT/2 : H_OUT`. Total beats = `C_OUT*Hs*Ws`.
- Counter advance on each accepted beat:
  - `col` increments.
  - At `col==Ws-1`, `col` wraps to 0 and `row` increments.
  - At `row==Hs-1` with the column wrap, `row` wraps to 0 and `ch` increments.
  - Last beat: `col==Ws-1 && row==Hs-1 && ch==C_OUT-1`.
- Address: a linear accumulator starts at `BASE` and increments by 1 per accepted beat. There is no multiplier. Width `ADDR_W` with modulo wrap; no overflow flag.
- Write port is registered. An accepted beat produces `wr_en=1`, `wr_addr` = pre-increment accumulator and `wr_data` = processed `in_data` on the next cycle. `wr_en` is 0 in every cycle that follows a non-accepting cycle.
- `start` in RUN, FLUSH or DONE is ignored. `u` changes after the accepted `start` have no effect until the next pass.
- Asynchronous reset at any time, including mid-pass, returns to IDLE. The partially written pass is abandoned; no `done`.

## Timing
- Reset values: `in_ready=0`, `wr_en=0`, `wr_addr=0`, `wr_data=0`, `col=0`, `row=0`, `ch=0`, `busy=0`, `done=0`, state IDLE.
- `start` at cycle t: `busy` and `in_ready` are high from t+1.
- Throughput is 1 beat/cycle. `in_valid` gaps stall the counters and produce `wr_en=0` bubbles.
- Last beat accepted at cycle t:
  - t+1: `wr_en` for the last beat, state FLUSH, `in_ready=0`.
  - t+2: `done=1`, state DONE, `busy=0`.
  - t+3: IDLE; `start` is accepted again from this cycle.
- Minimum pass length, full resolution with defaults: 256 accept cycles + 3.

## Configuration
- `OFMAP_RELU_EN`
  - Defined: `wr_data` = 0 when `in_data` is negative (MSB=1), else `in_data`. This is a ReLU fused into the write path at zero added latency.
  - Undefined: `wr_data = in_data` unmodified.
  - Both builds have identical handshake and timing.

## Test plan
- Defaults, `u=0`, `in_valid` held high: 256 writes, addresses 0..255 contiguous; `done` 2 cycles after the final accept; `col/row/ch` return to 0.
- `u=2`: exactly 64 writes, addresses 0..63; `ch` increments after every 16 beats; `done` pulses once.
- Random `in_valid` gaps (~50% duty): write sequence and addresses identical to the no-gap run; no `wr_en` during bubbles.
- `start` pulsed mid-RUN and during FLUSH: no restart, `col/row/ch` undisturbed, single `done`.
- Drop `rst` after 100 beats: all outputs at reset values immediately; a new `start` writes again from `BASE`.
- `OFMAP_RELU_EN` defined, `in_data=16'hFF85` -> `wr_data=0`; `in_data=16'h007B` -> `16'h007B`. Without the macro, `16'hFF85` passes through.
